// File: rtl/multi_ver_barrel.sv
// Multi-slot falling barrel engine: allocation, gravity, hit and landing.
// Optional macro MULTI_VER_BARREL_VMAX_EN caps barrel velocity at VMAX.
package multi_ver_barrel_pkg;
  localparam int VER_PIXELS         = 480;
  localparam int PLATFORM_HEIGHT    = 32;
  localparam int KONG_PLATFORM_YPOS = 64;
  localparam int CHARACTER_HEIGHT   = 48;
  localparam int BARREL_WIDTH       = 24;
  localparam int BARREL_HEIGHT      = 24;
  localparam int HIT_OFFSET         = 8;
endpackage

module multi_ver_barrel
  import multi_ver_barrel_pkg::*;
#(
  parameter int NUM_BARRELS = 4,
  parameter int TICK_CYCLES = 200000,
  parameter int FLOOR_Y     = VER_PIXELS - PLATFORM_HEIGHT,
  parameter int VMAX        = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     barrel,
  input  logic [10:0]              xpos_kong,
  input  logic [10:0]              xpos_donkey,
  input  logic [10:0]              ypos_donkey,
  output logic [11*NUM_BARRELS-1:0] xpos,
  output logic [11*NUM_BARRELS-1:0] ypos,
  output logic [NUM_BARRELS-1:0]   active,
  output logic [NUM_BARRELS-1:0]   done,
  output logic                     barrel_hit,
  output logic                     launch_drop
);

  localparam int CW = (TICK_CYCLES > 2) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [CW-1:0] TLAST = CW'(TICK_CYCLES - 1);
  localparam logic [10:0] SPAWN_Y = 11'(KONG_PLATFORM_YPOS + CHARACTER_HEIGHT);
  localparam logic [10:0] FLOOR = 11'(FLOOR_Y);
  localparam logic [11:0] XR = 12'(BARREL_WIDTH - HIT_OFFSET);
  localparam logic [11:0] XL = 12'(48 - HIT_OFFSET);
  localparam logic [11:0] YH = 12'(BARREL_HEIGHT);
`ifdef MULTI_VER_BARREL_VMAX_EN
  localparam logic [10:0] VCAP = 11'(VMAX);
`else
  localparam logic [10:0] VCAP = 11'd2047;
`endif

  typedef enum logic {IDLE, FALL} state_t;

  logic [NUM_BARRELS-1:0] hit;
  logic [NUM_BARRELS-1:0] retire;
  logic [NUM_BARRELS-1:0] free;
  logic [NUM_BARRELS-1:0] grant;
  logic                   ready;
  logic                   launch;

  // Launches are ignored for the first cycle out of reset.
  assign launch = barrel & ready;

  // Lowest-index idle slot wins; retiring slots are still busy.
  assign grant = free & (~free + NUM_BARRELS'(1));

  for (genvar i = 0; i < NUM_BARRELS; i++) begin : g_slot
    state_t          st;
    logic [10:0]     x_q;
    logic [10:0]     y_q;
    logic [10:0]     v_q;
    logic [CW-1:0]   cnt_q;
    logic [11:0]     ysum;
    logic [10:0]     ynext;
    logic            fall;
    logic            floor_hit;

    assign fall      = (st == FALL);
    assign floor_hit = (y_q == FLOOR);
    assign ysum      = {1'b0, y_q} + {1'b0, v_q};
    assign ynext     = (ysum >= {1'b0, FLOOR}) ? FLOOR : ysum[10:0];

    assign hit[i] = fall
      && ({1'b0, x_q} + XR >= {1'b0, xpos_donkey})
      && ({1'b0, x_q} <= {1'b0, xpos_donkey} + XL)
      && ({1'b0, y_q} + YH >= {1'b0, ypos_donkey})
      && ({1'b0, y_q} <= {1'b0, ypos_donkey} + YH);

    assign retire[i] = fall & (hit[i] | floor_hit);
    assign free[i]   = ~fall;
    assign active[i] = fall;
    assign xpos[11*i +: 11] = x_q;
    assign ypos[11*i +: 11] = y_q;

    // Per-slot FSM: spawn, gravity steps, retire on hit or landing.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        st    <= IDLE;
        x_q   <= '0;
        y_q   <= '0;
        v_q   <= '0;
        cnt_q <= '0;
      end else begin
        unique case (st)
          IDLE: begin
            if (launch && grant[i]) begin
              st    <= FALL;
              x_q   <= xpos_kong + 11'd12;
              y_q   <= SPAWN_Y;
              v_q   <= '0;
              cnt_q <= '0;
            end
          end
          FALL: begin
            if (hit[i]) begin
              st <= IDLE;
            end else if (floor_hit) begin
              st <= IDLE;
            end else if (cnt_q == TLAST) begin
              cnt_q <= '0;
              y_q   <= ynext;
              if (v_q < VCAP) v_q <= v_q + 11'd1;
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end
          default: st <= IDLE;
        endcase
      end
    end
  end

  // Shared registered pulses and the post-reset launch gate.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready       <= 1'b0;
      done        <= '0;
      barrel_hit  <= 1'b0;
      launch_drop <= 1'b0;
    end else begin
      ready       <= 1'b1;
      done        <= retire;
      barrel_hit  <= |hit;
      launch_drop <= launch & ~(|free);
    end
  end

endmodule

// File: tb/tb_multi_ver_barrel.sv
// Directed bench for multi_ver_barrel: table-driven hit box plus
// hand sequences for fall, allocation, multi-hit and async reset.
module tb_multi_ver_barrel;

  localparam int N = 2;
  localparam int SPAWN = 112;
  localparam int FLR = 448;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            barrel = 1'b0;
  logic [10:0]     xpos_kong = 11'd100;
  logic [10:0]     xpos_donkey = 11'd2000;
  logic [10:0]     ypos_donkey = 11'd0;
  logic [11*N-1:0] xpos;
  logic [11*N-1:0] ypos;
  logic [N-1:0]    active;
  logic [N-1:0]    done;
  logic            barrel_hit;
  logic            launch_drop;

  int checks = 0;
  int errors = 0;

  multi_ver_barrel #(
    .NUM_BARRELS(N),
    .TICK_CYCLES(4),
    .VMAX(3)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .barrel(barrel),
    .xpos_kong(xpos_kong),
    .xpos_donkey(xpos_donkey),
    .ypos_donkey(ypos_donkey),
    .xpos(xpos),
    .ypos(ypos),
    .active(active),
    .done(done),
    .barrel_hit(barrel_hit),
    .launch_drop(launch_drop)
  );

  always #5 clk = ~clk;

  typedef struct {
    int xd;
    int yd;
    bit hit;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    barrel = 1'b0;
    xpos_kong = 11'd100;
    xpos_donkey = 11'd2000;
    ypos_donkey = 11'd0;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic launch();
    barrel = 1'b1;
    tick();
    barrel = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_y;
    int exp_v;
    int prev_y;
    int k;
    int dexp[6];
`ifdef MULTI_VER_BARREL_VMAX_EN
    dexp = '{0, 1, 2, 3, 3, 3};
`else
    dexp = '{0, 1, 2, 3, 4, 5};
`endif
    vecs[0] = '{112, 122, 1'b1};
    vecs[1] = '{128, 122, 1'b1};
    vecs[2] = '{129, 122, 1'b0};
    vecs[3] = '{72, 122, 1'b1};
    vecs[4] = '{71, 122, 1'b0};
    vecs[5] = '{112, 136, 1'b1};
    vecs[6] = '{112, 137, 1'b0};
    vecs[7] = '{112, 88, 1'b1};
    vecs[8] = '{112, 87, 1'b0};
    vecs[9] = '{2000, 0, 1'b0};

    #2;
    chk("rst_active", 32'(active), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_xpos", 32'(xpos), 0);
    chk("rst_ypos", 32'(ypos), 0);
    chk("rst_hit", 32'(barrel_hit), 0);
    chk("rst_drop", 32'(launch_drop), 0);

    tick();
    rst_n = 1'b1;
    barrel = 1'b1;
    tick();
    chk("first_edge_ignored", 32'(active), 0);
    tick();
    barrel = 1'b0;
    chk("second_edge_launch", 32'(active), 1);
    chk("spawn_x", 32'(xpos[10:0]), 112);
    chk("spawn_y", 32'(ypos[10:0]), SPAWN);

    exp_y = SPAWN;
    exp_v = 0;
    k = 0;
    while (exp_y != FLR && k < 200) begin
      prev_y = int'(ypos[10:0]);
      repeat (4) tick();
      exp_y = (exp_y + exp_v > FLR) ? FLR : exp_y + exp_v;
`ifdef MULTI_VER_BARREL_VMAX_EN
      exp_v = (exp_v < 3) ? exp_v + 1 : 3;
`else
      exp_v = exp_v + 1;
`endif
      chk("fall_y", 32'(ypos[10:0]), 32'(exp_y));
      if (k < 6)
        chk("fall_delta", 32'(int'(ypos[10:0]) - prev_y), 32'(dexp[k]));
      k++;
    end
    chk("fall_active", 32'(active), 1);
    chk("fall_done_low", 32'(done), 0);
    tick();
    chk("land_done", 32'(done), 1);
    chk("land_active", 32'(active), 0);
    tick();
    chk("land_done_once", 32'(done), 0);
    chk("land_hold_y", 32'(ypos[10:0]), FLR);

    for (int i = 0; i < 10; i++) begin
      do_reset();
      launch();
      xpos_donkey = 11'(vecs[i].xd);
      ypos_donkey = 11'(vecs[i].yd);
      tick();
      chk($sformatf("vec%0d_hit", i), 32'(barrel_hit), 32'(vecs[i].hit));
      chk($sformatf("vec%0d_done", i), 32'(done[0]), 32'(vecs[i].hit));
      chk($sformatf("vec%0d_act", i), 32'(active[0]), 32'(!vecs[i].hit));
      xpos_donkey = 11'd2000;
      ypos_donkey = 11'd0;
      tick();
      chk($sformatf("vec%0d_hit_off", i), 32'(barrel_hit), 0);
      chk($sformatf("vec%0d_frz_x", i), 32'(xpos[10:0]), 112);
      chk($sformatf("vec%0d_frz_y", i), 32'(ypos[10:0]), SPAWN);
    end

    do_reset();
    barrel = 1'b1;
    tick();
    chk("alloc_s0", 32'(active), 1);
    xpos_kong = 11'd300;
    tick();
    chk("alloc_s1", 32'(active), 3);
    chk("alloc_s1_x", 32'(xpos[21:11]), 312);
    chk("alloc_nodrop", 32'(launch_drop), 0);
    tick();
    barrel = 1'b0;
    chk("drop_pulse", 32'(launch_drop), 1);
    chk("drop_keep", 32'(active), 3);
    tick();
    chk("drop_once", 32'(launch_drop), 0);

    do_reset();
    barrel = 1'b1;
    tick();
    tick();
    chk("multi_both", 32'(active), 3);
    xpos_donkey = 11'd112;
    ypos_donkey = 11'd122;
    tick();
    barrel = 1'b0;
    xpos_donkey = 11'd2000;
    ypos_donkey = 11'd0;
    chk("multi_hit", 32'(barrel_hit), 1);
    chk("multi_done", 32'(done), 3);
    chk("multi_idle", 32'(active), 0);
    chk("retire_no_alloc", 32'(launch_drop), 1);
    tick();
    chk("multi_hit_once", 32'(barrel_hit), 0);
    chk("multi_done_once", 32'(done), 0);

    do_reset();
    launch();
    repeat (9) tick();
    chk("mid_active", 32'(active), 1);
    chk("mid_y", 32'(ypos[10:0]), SPAWN + 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_active", 32'(active), 0);
    chk("async_x", 32'(xpos), 0);
    chk("async_y", 32'(ypos), 0);
    chk("async_done", 32'(done), 0);
    rst_n = 1'b1;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multi_ver_barrel.md
MULTI_VER_BARREL -- requirements
Module: multi_ver_barrel

Interface
REQ-001 Parameter NUM_BARRELS, default 4, number of independent falling-barrel slots (1..8).
REQ-002 Parameter TICK_CYCLES, default 200000, clock cycles per gravity step (>=2).
REQ-003 Parameter FLOOR_Y, default VER_PIXELS - PLATFORM_HEIGHT, landing y coordinate.
REQ-004 Parameter VMAX, default 16, terminal velocity in pixels per step (used only with the macro in REQ-027).
REQ-005 clk  input  1  system clock; all state changes on its rising edge.
REQ-006 rst_n  input  1  reset; asynchronous assertion, active-low.
REQ-007 barrel  input  1  launch request, sampled every cycle; one launch per high cycle.
REQ-008 xpos_kong  input  11  Kong x position at the launch cycle.
REQ-009 xpos_donkey / ypos_donkey  input  11 each  player position for hit detection.
REQ-010 xpos / ypos  output  11*NUM_BARRELS each  packed per-slot positions; slot i is at bits [11*i+10:11*i].
REQ-011 active  output  NUM_BARRELS  slot i is falling.
REQ-012 done  output  NUM_BARRELS  one-cycle pulse when slot i retires.
REQ-013 barrel_hit  output  1  one-cycle pulse when any slot hits the player.
REQ-014 launch_drop  output  1  one-cycle pulse when a launch is rejected because no slot is free.

Function
REQ-015 Each slot SHALL run a two-state FSM: IDLE and FALL. active[i] is high exactly when slot i is in FALL.
REQ-016 When barrel=1 in cycle t, the lowest-index slot in IDLE SHALL enter FALL at t+1 with xpos = xpos_kong+12, ypos = KONG_PLATFORM_YPOS+CHARACTER_HEIGHT, velocity = 0 and tick counter = 0.
REQ-017 A slot that retires in cycle t SHALL NOT be allocated in cycle t. If every slot is in FALL when barrel=1, launch_drop SHALL pulse at t+1 and no state SHALL change.
REQ-018 In FALL, the tick counter SHALL increment every cycle. When it equals TICK_CYCLES-1, the counter SHALL clear, ypos SHALL become min(ypos+velocity, FLOOR_Y), and velocity SHALL increment. The sum is computed in 12 bits, so no wrap occurs.
REQ-019 Hit condition for slot i in FALL: (x+BARREL_WIDTH-HIT_OFFSET >= xpos_donkey) and (x <= xpos_donkey+48-HIT_OFFSET) and (y+BARREL_HEIGHT >= ypos_donkey) and (y <= ypos_donkey+BARREL_HEIGHT). All sums are computed in 12 bits.
REQ-020 On a hit in cycle t: slot i SHALL go to IDLE at t+1, done[i] and barrel_hit SHALL pulse at t+1, and xpos/ypos SHALL freeze.
REQ-021 A slot in FALL with ypos == FLOOR_Y SHALL go to IDLE on the next edge and pulse done[i] for one cycle.
REQ-022 Hit SHALL take priority over floor landing in the same cycle; barrel_hit SHALL pulse at most once per cycle, even when several slots hit together.
REQ-023 An IDLE slot SHALL hold its last xpos/ypos. Consumers gate rendering with active.
REQ-024 Slots SHALL be fully independent apart from allocation order and the OR onto barrel_hit.

Reset
REQ-025 While rst_n=0, all slots SHALL be in IDLE and active, done, barrel_hit, launch_drop, xpos, ypos, velocity and counters SHALL all be 0. This applies immediately, including mid-fall.
REQ-026 After rst_n deasserts, the first launch SHALL be accepted no earlier than the second rising edge.

Configuration
REQ-027 Macro MULTI_VER_BARREL_VMAX_EN: when defined, velocity SHALL saturate at VMAX. When undefined, velocity SHALL saturate only at 2047, and VMAX SHALL be unused.

Verification
REQ-028 Scenario: TICK_CYCLES=4, xpos_kong=100, one barrel pulse, player far away -> slot0 active with xpos=112. ypos rises by 0,1,2,3… every 4 cycles until it reaches FLOOR_Y. done[0] pulses once, then active[0]=0.
REQ-029 Scenario: three pulses on consecutive cycles with NUM_BARRELS=2 -> slot0 and slot1 allocate, and the third request raises launch_drop for one cycle.
REQ-030 Scenario: player placed at barrel x, ypos_donkey = spawn y+10 -> barrel_hit and done[0] pulse on the same cycle, and xpos/ypos freeze.
REQ-031 Scenario: two slots overlapping the player in the same cycle -> a single barrel_hit pulse, with done pulsing for both slots.
REQ-032 Scenario: rst_n low mid-fall -> all outputs are 0 immediately, with no clock edge needed.
REQ-033 Scenario: with the macro defined and VMAX=3 -> per-step deltas of 0,1,2,3,3,3. Without the macro, the deltas keep growing.
